// File: rtl/face_pkg.sv
// face_pkg: frame geometry and capture state shared by the writer, BRAM and scaler.
package face_pkg;
  localparam int IMG_W = 640;
  localparam int IMG_H = 480;
  localparam int ADDR_W = 19;
  localparam int X_W = 10;
  localparam int Y_W = 9;
  localparam int FRAME_PIXELS = IMG_W * IMG_H;
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, READY} cap_state_t;
endpackage

// File: rtl/pixel_xy_counter.sv
// pixel_xy_counter: raster position of the pixel being accepted this cycle.
// Outputs are combinational from the stored next position; clear forces them to pixel 0.
module pixel_xy_counter #(
  parameter int IMG_W = face_pkg::IMG_W,
  parameter int IMG_H = face_pkg::IMG_H,
  parameter int ADDR_W = face_pkg::ADDR_W,
  parameter int X_W = face_pkg::X_W,
  parameter int Y_W = face_pkg::Y_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  logic [X_W-1:0] cx;
  logic [Y_W-1:0] cy;
  logic [ADDR_W-1:0] ca;
  logic eol;
  assign x = clear ? '0 : cx;
  assign y = clear ? '0 : cy;
  assign addr = clear ? '0 : ca;
  assign eol = x == X_W'(IMG_W - 1);
  assign last = addr == ADDR_W'(IMG_W * IMG_H - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cx <= '0;
      cy <= '0;
      ca <= '0;
    end else if (advance) begin
      cx <= eol ? '0 : x + 1'b1;
      cy <= last ? '0 : eol ? y + 1'b1 : y;
      ca <= last ? '0 : addr + 1'b1;
    end else if (clear) begin
      cx <= '0;
      cy <= '0;
      ca <= '0;
    end
endmodule

// File: rtl/frame_capture_writer.sv
// frame_capture_writer: captures one binarized frame per arm into the frame BRAM
// in raster order, then holds it until the scaler reports it consumed.
module frame_capture_writer #(
  parameter int IMG_W = face_pkg::IMG_W,
  parameter int IMG_H = face_pkg::IMG_H,
  parameter int ADDR_W = face_pkg::ADDR_W,
  parameter int X_W = face_pkg::X_W,
  parameter int Y_W = face_pkg::Y_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pix_sof,
  input  logic              pix_valid,
  input  logic              pix_data,
  input  logic              scale_done,
  output logic              wr_en,
  output logic              wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic              capturing,
  output logic              frame_ready,
  output logic              err_resync
);
  import face_pkg::*;
  cap_state_t state, next;
  logic [X_W-1:0] px;
  logic [Y_W-1:0] py;
  logic [ADDR_W-1:0] pa;
  logic last, arm_acc, cap_acc, resync, advance;
  assign arm_acc = state == ARMED && pix_valid && pix_sof;
  assign cap_acc = state == CAPTURE && pix_valid;
  assign resync = cap_acc && pix_sof;
  assign advance = arm_acc || cap_acc;
  pixel_xy_counter #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .X_W(X_W), .Y_W(Y_W)
  ) u_xy (
    .clk(clk), .rst(rst), .clear(arm_acc || resync), .advance(advance),
    .x(px), .y(py), .addr(pa), .last(last)
  );
  always_comb
    next = state == IDLE    ? (start ? ARMED : IDLE) :
           state == ARMED   ? (arm_acc ? CAPTURE : ARMED) :
           state == CAPTURE ? (cap_acc && !pix_sof && last ? READY : CAPTURE) :
                              (scale_done ? (start ? ARMED : IDLE) : READY);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      wr_en <= 1'b0;
      wr_data <= 1'b0;
      wr_addr <= '0;
      x <= '0;
      y <= '0;
      capturing <= 1'b0;
      frame_ready <= 1'b0;
      err_resync <= 1'b0;
    end else begin
      state <= next;
      wr_en <= advance;
      if (advance) begin
        wr_data <= pix_data;
        wr_addr <= pa;
        x <= px;
        y <= py;
      end
      capturing <= next == ARMED || next == CAPTURE;
      frame_ready <= state == READY && !scale_done;
      err_resync <= err_resync || resync;
    end
endmodule

// File: tb/tb_frame_capture_writer.sv
// tb_frame_capture_writer: scoreboard bench on a reduced 8x4 frame; the driver
// queues every expected BRAM write and a negedge monitor checks them as they appear.
module tb_frame_capture_writer;
  localparam int W = 8;
  localparam int H = 4;
  localparam int N = W * H;
  logic clk = 0, rst = 1, start = 0, pix_sof = 0, pix_valid = 0, pix_data = 0, scale_done = 0;
  logic wr_en, wr_data, capturing, frame_ready, err_resync;
  logic [4:0] wr_addr;
  logic [2:0] x;
  logic [1:0] y;
  int cyc = 0, ncmp = 0, nerr = 0;
  typedef struct {int a; logic d; int x; int y; int c;} exp_t;
  exp_t q[$];

  frame_capture_writer #(.IMG_W(W), .IMG_H(H), .ADDR_W(5), .X_W(3), .Y_W(2)) dut (
    .clk(clk), .rst(rst), .start(start), .pix_sof(pix_sof), .pix_valid(pix_valid),
    .pix_data(pix_data), .scale_done(scale_done), .wr_en(wr_en), .wr_data(wr_data),
    .wr_addr(wr_addr), .x(x), .y(y), .capturing(capturing), .frame_ready(frame_ready),
    .err_resync(err_resync)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (!rst && wr_en) begin
      ncmp++;
      if (q.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_write: got addr=%0d data=%0d, required no write", wr_addr, wr_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (wr_addr !== e.a || wr_data !== e.d || x !== e.x || y !== e.y || cyc != e.c) begin
          nerr++;
          $display("FAIL write: got addr=%0d data=%0d x=%0d y=%0d cyc=%0d, required addr=%0d data=%0d x=%0d y=%0d cyc=%0d",
                   wr_addr, wr_data, x, y, cyc, e.a, e.d, e.x, e.y, e.c);
        end
      end
    end

  task automatic check(input string name, input int got, input int want);
    ncmp++;
    if (got != want) begin
      nerr++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pat(input int a);
    return 1'((a % W) ^ (a / W));
  endfunction

  // One pixel strobe; wr says whether it must produce a write at address a.
  task automatic pix(input logic sof, input logic d, input bit wr, input int a);
    pix_valid = 1;
    pix_sof = sof;
    pix_data = d;
    if (wr) q.push_back('{a, d, a % W, a / W, cyc + 1});
    tick();
    pix_valid = 0;
    pix_sof = 0;
  endtask

  task automatic frame(input int from, input int gap);
    for (int a = from; a < N; a++) begin
      pix(a == 0, pat(a), 1, a);
      if (a != N - 1) repeat (gap) tick();
    end
  endtask

  task automatic ready_check(input string tag);
    check({tag, "_ready_after_last_wr"}, frame_ready, 0);
    check({tag, "_capturing_end"}, capturing, 0);
    tick();
    check({tag, "_ready"}, frame_ready, 1);
  endtask

  task automatic arm();
    start = 1;
    tick();
    start = 0;
    check("capturing_armed", capturing, 1);
  endtask

  initial begin
    #2;
    check("rst_wr_en", wr_en, 0);
    check("rst_outputs", {wr_data, wr_addr, x, y, capturing, frame_ready, err_resync}, 0);
    repeat (2) tick();
    rst = 0;
    repeat (2) tick();
    check("idle_capturing", capturing, 0);
    // nominal continuous frame
    arm();
    frame(0, 0);
    ready_check("nominal");
    // hold-off: pixels while READY produce nothing, scale_done returns to IDLE
    for (int i = 0; i < 10; i++) pix(i == 0, 1, 0, 0);
    check("holdoff_ready", frame_ready, 1);
    scale_done = 1;
    tick();
    scale_done = 0;
    check("done_ready_low", frame_ready, 0);
    check("done_idle", capturing, 0);
    // pixels in IDLE are ignored, then junk before SOF while ARMED, then 1-in-3 frame
    for (int i = 0; i < 3; i++) pix(1, 1, 0, 0);
    arm();
    for (int i = 0; i < 5; i++) pix(0, 1, 0, 0);
    frame(0, 2);
    ready_check("gapped");
    // rearm with start and scale_done together, then a resync at address 10
    start = 1;
    scale_done = 1;
    tick();
    start = 0;
    scale_done = 0;
    check("rearm_capturing", capturing, 1);
    check("rearm_ready_low", frame_ready, 0);
    for (int a = 0; a < 10; a++) pix(a == 0, pat(a), 1, a);
    check("no_resync_yet", err_resync, 0);
    pix(1, pat(0), 1, 0);
    check("resync_flag", err_resync, 1);
    frame(1, 0);
    ready_check("resync");
    check("resync_sticky", err_resync, 1);
    // rearm, then asynchronous reset mid-frame
    start = 1;
    scale_done = 1;
    tick();
    start = 0;
    scale_done = 0;
    for (int a = 0; a < 7; a++) pix(a == 0, pat(a), 1, a);
    @(negedge clk);
    #1;
    rst = 1;
    #1;
    check("async_rst_wr_en", wr_en, 0);
    check("async_rst_outputs", {wr_data, wr_addr, x, y, capturing, frame_ready, err_resync}, 0);
    tick();
    rst = 0;
    for (int i = 0; i < 4; i++) pix(i == 0, 1, 0, 0);
    check("post_rst_idle", capturing, 0);
    arm();
    for (int a = 0; a < 3; a++) pix(a == 0, pat(a), 1, a);
    repeat (3) tick();
    check("post_rst_no_resync", err_resync, 0);
    check("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
